// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a picorv32-style memory port: one whole
// transaction at a time, registered downstream request, per-transaction timeout.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_err,

  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,

  output logic [1:0]  grant
);

  // A one-bit counter is kept even when the timeout is disabled so the
  // datapath needs no generate split.
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          last_m1;    // 1 when master 1 owned the previous transaction
  logic [CW-1:0] cnt;

  logic          start;
  logic          pick_m1;
  logic          tmo_hit;
  logic          done;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    pick_m1 = 1'b0;
    tmo_hit = 1'b0;
    done    = 1'b0;

    case (state)
      S_IDLE: begin
        if (m0_valid || m1_valid) begin
          start   = 1'b1;
          state_n = S_BUSY;
          // On a tie the master that did not go last wins.
          pick_m1 = m1_valid && (!m0_valid || !last_m1);
        end
      end
      S_BUSY: begin
        tmo_hit = (TIMEOUT != 0) && (cnt == CNT_LAST) && !mem_ready;
        done    = mem_ready || tmo_hit;
        if (done) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Response routing: only the granted master ever sees ready, err or data.
  always_comb begin
    m0_ready = done && grant[0];
    m1_ready = done && grant[1];
    m0_err   = m0_ready && !mem_ready;
    m1_err   = m1_ready && !mem_ready;
    m0_rdata = (m0_ready && mem_ready) ? mem_rdata : 32'h0;
    m1_rdata = (m1_ready && mem_ready) ? mem_rdata : 32'h0;
  end

  // NOTE: sequential state uses non-blocking assignments and a synchronous
  // active-low reset, so a mid-transaction reset simply abandons the request.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
      grant     <= 2'b00;
      last_m1   <= 1'b1;
      cnt       <= '0;
    end else if (start) begin
      mem_valid <= 1'b1;
      mem_instr <= pick_m1 ? m1_instr : m0_instr;
      mem_addr  <= pick_m1 ? m1_addr  : m0_addr;
      mem_wdata <= pick_m1 ? m1_wdata : m0_wdata;
      mem_wstrb <= pick_m1 ? m1_wstrb : m0_wstrb;
      grant     <= pick_m1 ? 2'b10 : 2'b01;
      cnt       <= '0;
    end else if (done) begin
      // Address/data/strobes keep their value until the next grant.
      mem_valid <= 1'b0;
      grant     <= 2'b00;
      last_m1   <= grant[1];
    end else if (state == S_BUSY && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (TIMEOUT=8): reads, writes,
// round-robin order, timeout boundary and mid-transaction reset.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  grant;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .grant(grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_grant [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    reset = 1'b0;
    m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;
    tick(); tick();
    check("rst_mem_valid", 32'(mem_valid), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_m0_ready", 32'(m0_ready), 0);
    reset = 1'b1;
    tick();

    // Single read by m0, memory answers in the second BUSY cycle.
    m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 4'b0000;
    tick();
    check("rd_mem_valid", 32'(mem_valid), 1);
    check("rd_grant", 32'(grant), 32'b01);
    check("rd_addr", mem_addr, 32'h100);
    check("rd_wstrb", 32'(mem_wstrb), 0);
    check("rd_not_early", 32'(m0_ready), 0);
    tick();
    mem_ready = 1; mem_rdata = 32'hDEADBEEF; #1;
    check("rd_m0_ready", 32'(m0_ready), 1);
    check("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("rd_m0_err", 32'(m0_err), 0);
    check("rd_m1_ready", 32'(m1_ready), 0);
    check("rd_m1_rdata", m1_rdata, 0);
    tick();
    mem_ready = 0; m0_valid = 0; #1;
    check("rd_release_valid", 32'(mem_valid), 0);
    check("rd_release_grant", 32'(grant), 0);
    check("rd_addr_held", mem_addr, 32'h100);
    check("rd_ready_pulse", 32'(m0_ready), 0);
    tick();

    // Write by m1 with immediate completion.
    m1_valid = 1; m1_addr = 32'h8; m1_wdata = 32'h00001234; m1_wstrb = 4'b0011;
    tick();
    check("wr_grant", 32'(grant), 32'b10);
    check("wr_addr", mem_addr, 32'h8);
    check("wr_wdata", mem_wdata, 32'h00001234);
    check("wr_wstrb", 32'(mem_wstrb), 32'b0011);
    check("wr_instr", 32'(mem_instr), 0);
    mem_ready = 1; mem_rdata = 32'h55AA55AA; #1;
    check("wr_m1_ready", 32'(m1_ready), 1);
    check("wr_m0_ready", 32'(m0_ready), 0);
    check("wr_m0_rdata", m0_rdata, 0);
    tick();
    mem_ready = 0; m1_valid = 0;
    tick();

    // Tie out of reset, both masters holding valid: order m0, m1, m0, m1.
    reset = 0;
    tick();
    reset = 1;
    m0_valid = 1; m0_addr = 32'hA0; m1_valid = 1; m1_addr = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rr_grant%0d", i), 32'(grant), 32'(exp_grant[i]));
      check($sformatf("rr_addr%0d", i), mem_addr, exp_grant[i][0] ? 32'hA0 : 32'hB0);
      mem_ready = 1; #1;
      check($sformatf("rr_m0_ready%0d", i), 32'(m0_ready), 32'(exp_grant[i][0]));
      check($sformatf("rr_m1_ready%0d", i), 32'(m1_ready), 32'(exp_grant[i][1]));
      tick();
      mem_ready = 0; #1;
      check($sformatf("rr_idle%0d", i), 32'(grant), 0);
    end

    // m0 alone streams back-to-back; once m1 waits it must win the next grant.
    m1_valid = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("solo_grant%0d", i), 32'(grant), 32'b01);
      mem_ready = 1;
      if (i == 1) m1_valid = 1;
      tick();
      mem_ready = 0;
    end
    tick();
    check("waiter_grant", 32'(grant), 32'b10);
    mem_ready = 1;
    m0_valid = 0;
    tick();
    mem_ready = 0; m1_valid = 0;
    tick();

    // Timeout: memory never answers; error response in the 8th BUSY cycle.
    m0_valid = 1; m0_addr = 32'h200; mem_rdata = 32'h12345678;
    tick();
    for (int c = 1; c < 8; c++) begin
      check($sformatf("tmo_wait%0d", c), 32'(m0_ready), 0);
      tick();
    end
    check("tmo_ready", 32'(m0_ready), 1);
    check("tmo_err", 32'(m0_err), 1);
    check("tmo_rdata", m0_rdata, 0);
    check("tmo_m1_ready", 32'(m1_ready), 0);
    tick();
    m0_valid = 0;
    check("tmo_release", 32'(mem_valid), 0);
    tick();

    // Same, but memory answers in the 8th cycle: normal completion.
    m0_valid = 1;
    tick();
    for (int c = 1; c < 8; c++) tick();
    mem_ready = 1; mem_rdata = 32'h0000CAFE; #1;
    check("late_ready", 32'(m0_ready), 1);
    check("late_err", 32'(m0_err), 0);
    check("late_rdata", m0_rdata, 32'h0000CAFE);
    tick();
    mem_ready = 0; m0_valid = 0;
    tick();

    // Reset while m1's transaction is outstanding.
    m1_valid = 1; m1_instr = 1; m1_addr = 32'h300; m1_wdata = 32'hFFFF0000; m1_wstrb = 4'hF;
    tick();
    check("mid_busy_grant", 32'(grant), 32'b10);
    reset = 0;
    tick();
    check("mid_mem_valid", 32'(mem_valid), 0);
    check("mid_grant", 32'(grant), 0);
    check("mid_addr", mem_addr, 0);
    check("mid_wdata", mem_wdata, 0);
    check("mid_wstrb", 32'(mem_wstrb), 0);
    check("mid_instr", 32'(mem_instr), 0);
    mem_ready = 1; #1;
    check("mid_no_resp", 32'(m1_ready), 0);
    mem_ready = 0;
    m0_valid = 1; m0_addr = 32'h400;
    reset = 1;
    tick();
    check("post_rst_grant", 32'(grant), 32'b01);
    check("post_rst_addr", mem_addr, 32'h400);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares one picorv32-style memory port between requesters, such as the CPU's instruction/data master and a debug or DMA master. It grants the port one whole transaction at a time using round-robin priority. It registers the winning request onto the downstream bus and routes the response back to the granted master only. A per-transaction timeout guarantees that a hung memory cannot wedge the bus.

## Interface
Parameters
- TIMEOUT, 1024: maximum cycles `mem_valid` may stay high without `mem_ready`; 0 disables the timeout. Counter width is clog2(TIMEOUT+1).

Ports
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- m0_valid  in  1  master 0 request; held high until m0_ready
- m0_instr  in  1  master 0 instruction-fetch flag
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes; 0000 = read
- m0_ready  out  1  master 0 transaction complete, one-cycle pulse
- m0_rdata  out  32  master 0 read data, valid while m0_ready
- m0_err  out  1  master 0 timeout flag, only with m0_ready
- m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata, m1_err: same as m0_* for master 1
- mem_valid  out  1  downstream request
- mem_instr  out  1  downstream fetch flag
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_wstrb  out  4  downstream strobes
- mem_ready  in  1  downstream completion
- mem_rdata  in  32  downstream read data
- grant  out  2  one-hot current owner; 00 when idle

## Operation
- **States**
  - IDLE: no transaction in flight.
  - BUSY: downstream transaction outstanding.
- **IDLE → BUSY**, when m0_valid or m1_valid is high.
  - Only one valid: that master wins.
  - Both valid: the master not in `last_grant` wins.
  - On the same edge: latch the winner's instr/addr/wdata/wstrb onto mem_*; set mem_valid=1; set grant to the winner; clear the timeout counter.
- **Request sampling**: requests are sampled only in IDLE. Master inputs are ignored in BUSY.
- **Normal completion**: in BUSY with mem_ready=1:
  - The granted master gets ready=1 and rdata=mem_rdata (combinational, same cycle); err=0.
  - Next edge: mem_valid←0, grant←00, last_grant←winner, state←IDLE.
- **Timeout**: in BUSY with TIMEOUT≠0, counter==TIMEOUT−1 and mem_ready=0:
  - The granted master gets ready=1, err=1, rdata=0.
  - Next edge: same release as normal completion.
- **Counter**: increments every BUSY cycle without mem_ready and saturates.
- **Completion vs. timeout**: mem_ready in the timeout cycle is a normal completion (err=0).
- **Non-granted master**: its ready, err and rdata stay 0 at all times.
- **Pass-through**: mem_addr, mem_wdata, mem_wstrb and mem_instr hold their latched value until the next grant; they are not cleared on completion.
- **Reset, including mid-transaction**:
  - State IDLE, last_grant=m1 so m0 wins the first tie, counter 0.
  - All registered outputs 0: mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, grant.
  - Combinational outputs m*_ready, m*_err and m*_rdata read 0 because state is IDLE.
  - Any in-flight downstream transaction is abandoned; no response is sent to the master.

## Timing
- **Grant latency**: request valid at IDLE cycle N → mem_valid=1 and grant set at cycle N+1.
- **Response latency**: mem_ready at cycle M → master ready at cycle M (zero added latency) → IDLE at M+1.
- **Next grant**: earliest at M+1, so the next mem_valid rises at M+2; there is always ≥1 idle cycle between downstream transactions.
- **Back-to-back**: the master must drop valid on the edge after it sees ready. A valid still high at M+1 is a new request and competes under round-robin.
- **Timeout timing**: first BUSY cycle is counter 0; with TIMEOUT=T, the error response appears in the T-th BUSY cycle.
- **Combinational paths**: the only paths are mem_ready/mem_rdata → m*_ready/m*_rdata/m*_err. No path exists from master inputs to mem_*.

## Test plan
- **Single read**: m0 read of addr 0x100; mem_ready 2 cycles after mem_valid, rdata 0xDEADBEEF.
  - mem_valid rises 1 cycle after m0_valid; mem_addr 0x100, wstrb 0000, grant 01.
  - m0_ready pulses for one cycle with 0xDEADBEEF; m1_ready stays 0.
- **Write pass-through**: m1 writes addr 0x8, wdata 0x00001234, wstrb 0011.
  - mem_* match exactly, grant 10.
  - m1_ready pulses once; m0_ready never asserts.
- **Tie after reset, then alternation**: m0 and m1 request simultaneously out of reset.
  - m0 is served first, then m1.
  - Both re-request: m0 again. Verify order m0, m1, m0, m1.
- **Continuous master with a waiter**: m0 requests back-to-back while m1 waits.
  - After m0's transaction, m1 gets the next grant.
  - m0 never receives two consecutive grants while m1 is pending.
- **Timeout**: TIMEOUT=8, mem_ready never asserted.
  - In the 8th BUSY cycle, m0_ready=1, m0_err=1, m0_rdata=0.
  - mem_valid falls next cycle.
  - Repeat with mem_ready in the 8th cycle: completes with err=0.
- **Reset mid-transaction**: drive reset=0 while BUSY.
  - Next cycle: mem_valid=0, grant=00, all mem_* = 0, no master ready.
  - After reset release with both masters requesting, m0 is granted first.
